motion_bbox: RTL and testbench

- Consumes the saturated binary motion mask from the delta-frame stage, one pixel per clock during active video.
- Accumulates per frame:
  - the bounding box of motion pixels (min/max x, min/y max y);
  - the count of accepted motion pixels.
- At end of frame, publishes box, centre and a valid flag to the tracking/overlay logic.
- Suppresses speckle noise: a pixel counts only once it completes a horizontal run of RUN_MIN consecutive mask hits.

---
 rtl/motion_pkg.sv | 18 +
 rtl/motion_bbox_if.sv | 31 +++
 rtl/motion_bbox_run_filter.sv | 52 +++++
 rtl/motion_bbox.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_motion_bbox.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared types and defaults for the motion bounding-box tracker.
// FSM state encoding plus default widths and run length.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int X_WIDTH_DEF    = 10;
  localparam int Y_WIDTH_DEF    = 10;
  localparam int CNT_WIDTH_DEF  = 20;
  localparam int RUN_MIN_DEF    = 3;
  localparam int RUN_WIDTH      = 3;

endpackage

// File: rtl/motion_bbox_if.sv
// Pixel stream from the delta-frame stage into the bbox tracker.
// Ports: pix_valid, sof, eol, eof, mask_in; master drives, slave consumes.
interface motion_bbox_if
  import motion_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  pix_valid;
  logic                  sof;
  logic                  eol;
  logic                  eof;
  logic [DATA_WIDTH-1:0] mask_in;

  modport master (
    output pix_valid,
    output sof,
    output eol,
    output eof,
    output mask_in
  );

  modport slave (
    input pix_valid,
    input sof,
    input eol,
    input eof,
    input mask_in
  );

endinterface

// File: rtl/motion_bbox_run_filter.sv
// Horizontal run filter: accepts a hit once RUN_MIN consecutive hits seen.
// In: en/hit/sof/eol of the processed pixel. Out: accept, qualify (run start).
module bbox_run_filter
  import motion_pkg::*;
#(
  parameter int RUN_MIN = RUN_MIN_DEF
) (
  input  logic clk,
  input  logic aresetn,
  input  logic en,
  input  logic hit,
  input  logic sof,
  input  logic eol,
  output logic accept,
  output logic qualify
);

  localparam logic [RUN_WIDTH:0] RMIN =
    (RUN_WIDTH+1)'(RUN_MIN);

  logic [RUN_WIDTH-1:0] run_q;
  logic [RUN_WIDTH-1:0] run_d;
  logic [RUN_WIDTH-1:0] run_base;
  logic [RUN_WIDTH:0]   run_inc;

  always_comb begin
    run_base = sof ? '0 : run_q;
    run_inc  = {1'b0, run_base} + 1'b1;
    accept   = en && hit && (run_inc >= RMIN);
    // run saturates at RUN_MIN, so equality marks the first qualifying hit
    qualify  = accept && (run_inc == RMIN);
    run_d    = run_q;
    if (en) begin
      if (!hit || eol) begin
        run_d = '0;
      end else if (run_inc >= RMIN) begin
        run_d = RMIN[RUN_WIDTH-1:0];
      end else begin
        run_d = run_inc[RUN_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/motion_bbox.sv
// Per-frame bounding box, centre and pixel count of the motion mask.
// Ports: clk, aresetn, pix (stream slave), min_count; box/centre/count/flags out.
module motion_bbox
  import motion_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int X_WIDTH    = X_WIDTH_DEF,
  parameter int Y_WIDTH    = Y_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int RUN_MIN    = RUN_MIN_DEF
) (
  input  logic                 clk,
  input  logic                 aresetn,
  motion_bbox_if.slave         pix,
  input  logic [CNT_WIDTH-1:0] min_count,
  output logic [X_WIDTH-1:0]   box_x0,
  output logic [X_WIDTH-1:0]   box_x1,
  output logic [Y_WIDTH-1:0]   box_y0,
  output logic [Y_WIDTH-1:0]   box_y1,
  output logic [X_WIDTH-1:0]   center_x,
  output logic [Y_WIDTH-1:0]   center_y,
  output logic [CNT_WIDTH-1:0] pix_count,
  output logic                 box_valid,
  output logic                 frame_done,
  output logic                 frame_err
);

  state_e state_q, state_d;

  logic proc, publish, restart_err;
  logic hit, line_end, accept, qualify;
  logic sat, has_base, pub_valid;
  logic unused_mask;

  logic [X_WIDTH-1:0] x_q, x_d, cur_x;
  logic [X_WIDTH-1:0] run_start, lo_x;
  logic [X_WIDTH-1:0] min_x_q, min_x_d;
  logic [X_WIDTH-1:0] max_x_q, max_x_d;
  logic [Y_WIDTH-1:0] y_q, y_d, cur_y;
  logic [Y_WIDTH-1:0] min_y_q, min_y_d;
  logic [Y_WIDTH-1:0] max_y_q, max_y_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_base, cnt_add;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] min_cnt_q, min_cnt_d;
  logic                 has_hit_q, has_hit_d;
  logic                 err_q, err_d;

  logic [X_WIDTH-1:0]   box_x0_q, box_x0_d;
  logic [X_WIDTH-1:0]   box_x1_q, box_x1_d;
  logic [Y_WIDTH-1:0]   box_y0_q, box_y0_d;
  logic [Y_WIDTH-1:0]   box_y1_q, box_y1_d;
  logic [X_WIDTH-1:0]   ctr_x_q, ctr_x_d;
  logic [Y_WIDTH-1:0]   ctr_y_q, ctr_y_d;
  logic [CNT_WIDTH-1:0] pix_count_q, pix_count_d;
  logic                 box_valid_q, box_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_err_q, frame_err_d;
  logic [X_WIDTH-1:0]   pub_x0, pub_x1;
  logic [Y_WIDTH-1:0]   pub_y0, pub_y1;
  logic [X_WIDTH:0]     sum_x;
  logic [Y_WIDTH:0]     sum_y;

  assign hit         = pix.mask_in[DATA_WIDTH-1];
  assign unused_mask = ^pix.mask_in[DATA_WIDTH-2:0];
  // eof without eol still closes the line
  assign line_end    = pix.eol || pix.eof;

  bbox_run_filter #(
    .RUN_MIN (RUN_MIN)
  ) u_filter (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (proc),
    .hit     (hit),
    .sof     (pix.sof),
    .eol     (line_end),
    .accept  (accept),
    .qualify (qualify)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pix.pix_valid && pix.sof) begin
          state_d = pix.eof ? PUBLISH : ACCUM;
        end
      end
      ACCUM: begin
        if (pix.pix_valid && pix.eof) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        if (pix.pix_valid && pix.sof) begin
          state_d = pix.eof ? PUBLISH : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    proc        = 1'b0;
    publish     = 1'b0;
    restart_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        proc = pix.pix_valid && pix.sof;
      end
      ACCUM: begin
        proc        = pix.pix_valid;
        restart_err = pix.pix_valid && pix.sof;
      end
      PUBLISH: begin
        publish = 1'b1;
        proc    = pix.pix_valid && pix.sof;
      end
      default: ;
    endcase
  end

  // sof restarts the frame at (0,0) with empty accumulators
  always_comb begin
    cur_x     = pix.sof ? '0 : x_q;
    cur_y     = pix.sof ? '0 : y_q;
    cnt_base  = pix.sof ? '0 : cnt_q;
    has_base  = pix.sof ? 1'b0 : has_hit_q;
    run_start = cur_x - X_WIDTH'(RUN_MIN - 1);
    lo_x      = qualify ? run_start : cur_x;
    cnt_add   = qualify ? CNT_WIDTH'(RUN_MIN)
                        : CNT_WIDTH'(1);
    cnt_sum   = {1'b0, cnt_base} + {1'b0, cnt_add};
    sat       = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    min_x_d   = min_x_q;
    max_x_d   = max_x_q;
    min_y_d   = min_y_q;
    max_y_d   = max_y_q;
    cnt_d     = cnt_q;
    has_hit_d = has_hit_q;
    min_cnt_d = min_cnt_q;
    err_d     = err_q;
    if (proc) begin
      y_d = cur_y;
      if (line_end) begin
        x_d = '0;
        if (!pix.eof) begin
          if (&cur_y) sat = 1'b1;
          else        y_d = cur_y + 1'b1;
        end
      end else begin
        if (&cur_x) begin
          sat = 1'b1;
          x_d = cur_x;
        end else begin
          x_d = cur_x + 1'b1;
        end
      end
      err_d     = (pix.sof ? 1'b0 : err_q) | sat;
      cnt_d     = cnt_base;
      has_hit_d = has_base;
      if (accept) begin
        has_hit_d = 1'b1;
        cnt_d     = cnt_sum[CNT_WIDTH] ? '1
                                       : cnt_sum[CNT_WIDTH-1:0];
        if (!has_base) begin
          min_x_d = lo_x;
          max_x_d = cur_x;
          min_y_d = cur_y;
          max_y_d = cur_y;
        end else begin
          if (lo_x < min_x_q)  min_x_d = lo_x;
          if (cur_x > max_x_q) max_x_d = cur_x;
          if (cur_y < min_y_q) min_y_d = cur_y;
          if (cur_y > max_y_q) max_y_d = cur_y;
        end
      end
      if (pix.eof) min_cnt_d = min_count;
    end
  end

  always_comb begin
    pub_valid    = has_hit_q && (cnt_q >= min_cnt_q);
    pub_x0       = pub_valid ? min_x_q : '0;
    pub_x1       = pub_valid ? max_x_q : '0;
    pub_y0       = pub_valid ? min_y_q : '0;
    pub_y1       = pub_valid ? max_y_q : '0;
    sum_x        = {1'b0, pub_x0} + {1'b0, pub_x1};
    sum_y        = {1'b0, pub_y0} + {1'b0, pub_y1};
    box_x0_d     = box_x0_q;
    box_x1_d     = box_x1_q;
    box_y0_d     = box_y0_q;
    box_y1_d     = box_y1_q;
    ctr_x_d      = ctr_x_q;
    ctr_y_d      = ctr_y_q;
    pix_count_d  = pix_count_q;
    box_valid_d  = box_valid_q;
    frame_done_d = publish;
    frame_err_d  = (publish && err_q) || restart_err;
    if (publish) begin
      box_x0_d    = pub_x0;
      box_x1_d    = pub_x1;
      box_y0_d    = pub_y0;
      box_y1_d    = pub_y1;
      ctr_x_d     = sum_x[X_WIDTH:1];
      ctr_y_d     = sum_y[Y_WIDTH:1];
      pix_count_d = cnt_q;
      box_valid_d = pub_valid;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_q          <= '0;
      y_q          <= '0;
      min_x_q      <= '0;
      max_x_q      <= '0;
      min_y_q      <= '0;
      max_y_q      <= '0;
      cnt_q        <= '0;
      has_hit_q    <= 1'b0;
      min_cnt_q    <= '0;
      err_q        <= 1'b0;
      box_x0_q     <= '0;
      box_x1_q     <= '0;
      box_y0_q     <= '0;
      box_y1_q     <= '0;
      ctr_x_q      <= '0;
      ctr_y_q      <= '0;
      pix_count_q  <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      cnt_q        <= cnt_d;
      has_hit_q    <= has_hit_d;
      min_cnt_q    <= min_cnt_d;
      err_q        <= err_d;
      box_x0_q     <= box_x0_d;
      box_x1_q     <= box_x1_d;
      box_y0_q     <= box_y0_d;
      box_y1_q     <= box_y1_d;
      ctr_x_q      <= ctr_x_d;
      ctr_y_q      <= ctr_y_d;
      pix_count_q  <= pix_count_d;
      box_valid_q  <= box_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign box_x0     = box_x0_q;
  assign box_x1     = box_x1_q;
  assign box_y0     = box_y0_q;
  assign box_y1     = box_y1_q;
  assign center_x   = ctr_x_q;
  assign center_y   = ctr_y_q;
  assign pix_count  = pix_count_q;
  assign box_valid  = box_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_motion_bbox.sv
// Directed frame vectors and corner sequences for motion_bbox.
// Drives the pixel interface on negedges and checks outputs on negedges.
module tb_motion_bbox;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [19:0] min_count = '0;
  logic [9:0]  box_x0, box_x1, box_y0, box_y1;
  logic [9:0]  center_x, center_y;
  logic [19:0] pix_count;
  logic        box_valid, frame_done, frame_err;

  motion_bbox_if #(.DATA_WIDTH(10)) pif ();

  motion_bbox dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .pix        (pif),
    .min_count  (min_count),
    .box_x0     (box_x0),
    .box_x1     (box_x1),
    .box_y0     (box_y0),
    .box_y1     (box_y1),
    .center_x   (center_x),
    .center_y   (center_y),
    .pix_count  (pix_count),
    .box_valid  (box_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    int          h;
    logic [63:0] rows;
    int          gx;
    int          gy;
    int          mc;
    int          x0, y0, x1, y1;
    int          cx, cy, cnt;
    int          val;
  } vec_t;

  vec_t tbl[8];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   spurious = 0;
  logic [80:0] outs, prev_o;

  assign outs = {box_x0, box_y0, box_x1, box_y1,
                 center_x, center_y, pix_count, box_valid};

  initial prev_o = '0;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (aresetn && !frame_done && outs !== prev_o) spurious++;
    prev_o = outs;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(
    int w, int h, logic [63:0] rows, int gx, int gy, int mc,
    int x0, int y0, int x1, int y1, int cx, int cy,
    int cnt, int val);
    vec_t v;
    v.w = w; v.h = h; v.rows = rows;
    v.gx = gx; v.gy = gy; v.mc = mc;
    v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1;
    v.cx = cx; v.cy = cy; v.cnt = cnt; v.val = val;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_drive();
    pif.pix_valid = 1'b0;
    pif.sof       = 1'($urandom);
    pif.eol       = 1'($urandom);
    pif.eof       = 1'($urandom);
    pif.mask_in   = 10'($urandom);
  endtask

  task automatic drive_pixels(input vec_t v,
                              input int first,
                              input int last);
    int x;
    int y;
    for (int p = first; p <= last; p++) begin
      x = p % v.w;
      y = p / v.w;
      if (x == v.gx && y == v.gy) begin
        repeat (4) begin
          @(negedge clk);
          idle_drive();
        end
      end
      @(negedge clk);
      min_count     = 20'(v.mc);
      pif.pix_valid = 1'b1;
      pif.sof       = (p == 0);
      pif.eol       = (x == v.w - 1);
      pif.eof       = (p == v.w * v.h - 1);
      pif.mask_in   = v.rows[8*y + x] ? 10'h3ff : 10'h000;
    end
  endtask

  task automatic publish_check(input vec_t v, input int id);
    @(negedge clk);
    idle_drive();
    chk($sformatf("v%0d done_early", id), 64'(frame_done), 0);
    @(negedge clk);
    chk($sformatf("v%0d done", id), 64'(frame_done), 1);
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", id), 64'(frame_done), 0);
    chk($sformatf("v%0d x0", id), 64'(box_x0), 64'(v.x0));
    chk($sformatf("v%0d y0", id), 64'(box_y0), 64'(v.y0));
    chk($sformatf("v%0d x1", id), 64'(box_x1), 64'(v.x1));
    chk($sformatf("v%0d y1", id), 64'(box_y1), 64'(v.y1));
    chk($sformatf("v%0d cx", id), 64'(center_x), 64'(v.cx));
    chk($sformatf("v%0d cy", id), 64'(center_y), 64'(v.cy));
    chk($sformatf("v%0d cnt", id), 64'(pix_count), 64'(v.cnt));
    chk($sformatf("v%0d valid", id), 64'(box_valid), 64'(v.val));
  endtask

  task automatic run_vec(input int id);
    drive_pixels(tbl[id], 0, tbl[id].w * tbl[id].h - 1);
    publish_check(tbl[id], id);
  endtask

  initial begin
    int d0;
    int e0;
    tbl[0] = mkv(8, 4, 64'h0000_0000_0078_0000, -1, -1, 1,
                 3, 2, 6, 2, 4, 2, 4, 1);
    tbl[1] = mkv(8, 4, 64'h0000_0000_61C0_1805, -1, -1, 1,
                 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mkv(8, 4, 64'h0000_0000_0007_C000, -1, -1, 1,
                 0, 2, 2, 2, 1, 2, 3, 1);
    tbl[3] = mkv(8, 2, 64'h0000_0000_0000_3C00, 4, 1, 1,
                 2, 1, 5, 1, 3, 1, 4, 1);
    tbl[4] = mkv(8, 8, 64'h003C_F000_0000_0E00, -1, -1, 12,
                 0, 0, 0, 0, 0, 0, 11, 0);
    tbl[5] = mkv(8, 8, 64'h003C_F000_0000_0E00, -1, -1, 11,
                 1, 1, 7, 6, 4, 3, 11, 1);
    tbl[6] = mkv(8, 1, 64'h0000_0000_0000_00E0, -1, -1, 3,
                 5, 0, 7, 0, 6, 0, 3, 1);
    tbl[7] = mkv(8, 8, 64'h1F1F_1F1F_1F1F_1F1F, -1, -1, 50,
                 0, 0, 0, 0, 0, 0, 40, 0);

    idle_drive();
    repeat (3) @(negedge clk);
    chk("reset outs", 64'(outs), 0);
    chk("reset flags", 64'({frame_done, frame_err}), 0);
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);
    chk("no err in clean frames", 64'(err_cnt), 0);

    e0 = err_cnt;
    drive_pixels(tbl[7], 0, 10);
    drive_pixels(tbl[0], 0, 31);
    chk("abort keeps count", 64'(pix_count), 40);
    publish_check(tbl[0], 100);
    chk("abort err pulses", 64'(err_cnt - e0), 1);

    d0 = done_cnt;
    e0 = err_cnt;
    drive_pixels(tbl[2], 0, 31);
    drive_pixels(tbl[6], 0, 7);
    publish_check(tbl[6], 106);
    chk("b2b done pulses", 64'(done_cnt - d0), 2);
    chk("b2b err pulses", 64'(err_cnt - e0), 0);
    chk("outs only move with done", 64'(spurious), 0);

    run_vec(7);
    drive_pixels(tbl[7], 0, 27);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async reset outs", 64'(outs), 0);
    chk("async reset flags", 64'({frame_done, frame_err}), 0);
    @(negedge clk);
    idle_drive();
    @(negedge clk);
    aresetn = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_pixels(tbl[7], 28, 63);
    repeat (6) begin
      @(negedge clk);
      idle_drive();
    end
    chk("no done without sof", 64'(done_cnt - d0), 0);
    chk("no err without sof", 64'(err_cnt - e0), 0);
    chk("count after reset", 64'(pix_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
